// File: rtl/qu_common.sv
// Shared fetch-stage types: PC type, fetch FSM states and the {pc, instr} queue entry.
package qu_common;

  typedef logic [31:0] pc_t;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    pc_t         pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic pc_t align_pc(input pc_t pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_checker.sv
// Protocol and bookkeeping invariants of the fetch stage.
module fetch_checker
  import qu_common::*;
#(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  input fetch_state_t  state,
  input logic [CW-1:0] outstanding,
  input logic          imem_resp_valid,
  input logic          q_full,
  input logic          req_fire,
  input logic          resp_push,
  input logic          pcq_empty,
  input logic          pcq_full,
  input logic [CW-1:0] pcq_count,
  input fetch_entry_t  pcq_head
);

  a_no_resp_on_full: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && q_full));

  a_resp_has_pc: assert property (@(posedge clk) disable iff (rst)
    resp_push |-> !pcq_empty);

  a_pcq_room: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !pcq_full);

  // Every live in-flight request owns exactly one PC FIFO entry while running.
  a_pcq_tracks: assert property (@(posedge clk) disable iff (rst)
    (state == FETCH_RUN) |-> (pcq_count == outstanding));

  a_pcq_payload: assert property (@(posedge clk) disable iff (rst)
    pcq_head.instr == 32'h0);

endmodule

// File: rtl/instr_queue.sv
// Synchronous FIFO of fetch_entry_t with flush; head is read straight from registered storage.
module instr_queue
  import qu_common::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // A push into a full queue is only taken when a pop frees the slot in the same cycle.
  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: in-order imem requests, PC-tagged instruction queue, redirect flush.
// Optional QU_FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch
  import qu_common::*;
#(
  parameter int  INSTR_WIDTH = 32,
  parameter int  IQ_DEPTH    = 4,
  parameter pc_t RESET_PC    = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  pc_t                    redirect_pc,
  output logic                   imem_req_valid,
  output pc_t                    imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output pc_t                    pc_out,
  input  logic                   instr_ready
`ifdef QU_FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall
`endif
);

  localparam int          CW      = $clog2(IQ_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(IQ_DEPTH);

  fetch_state_t  state_r;
  pc_t           pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;

  logic          req_fire_s;
  logic          resp_dec_s;
  logic          resp_push_s;
  logic          q_pop_s;
  logic [CW:0]   credit_used_s;
  logic [CW-1:0] drop_next_s;

  fetch_entry_t  q_push_data_s;
  fetch_entry_t  q_head_s;
  logic          q_full_s;
  logic          q_empty_s;
  logic [CW-1:0] q_count_s;

  fetch_entry_t  pcq_push_data_s;
  fetch_entry_t  pcq_head_s;
  logic          pcq_full_s;
  logic          pcq_empty_s;
  logic [CW-1:0] pcq_count_s;

  // Credits cover both queued words and requests still in flight, so the queue never overflows.
  assign credit_used_s  = {1'b0, outstanding_r} + {1'b0, q_count_s};
  assign imem_req_valid = !rst && (state_r == FETCH_RUN) && (credit_used_s < CREDITS) && !redirect_valid;
  assign imem_req_addr  = pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  assign resp_dec_s  = imem_resp_valid && (outstanding_r != '0);
  assign resp_push_s = imem_resp_valid && (state_r == FETCH_RUN) && !redirect_valid;
  assign drop_next_s = outstanding_r - CW'(resp_dec_s);

  assign instr_valid = !q_empty_s;
  assign instr_out   = INSTR_WIDTH'(q_head_s.instr);
  assign pc_out      = q_head_s.pc;
  assign q_pop_s     = instr_valid && instr_ready;

  assign q_push_data_s   = '{pc: pcq_head_s.pc, instr: 32'(imem_resp_data)};
  assign pcq_push_data_s = '{pc: pc_r, instr: 32'h0};

  instr_queue #(.DEPTH(IQ_DEPTH), .CW(CW)) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_push_s),
    .push_data (q_push_data_s),
    .pop       (q_pop_s),
    .head      (q_head_s),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .count     (q_count_s)
  );

  instr_queue #(.DEPTH(IQ_DEPTH), .CW(CW)) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire_s),
    .push_data (pcq_push_data_s),
    .pop       (resp_push_s),
    .head      (pcq_head_s),
    .full      (pcq_full_s),
    .empty     (pcq_empty_s),
    .count     (pcq_count_s)
  );

  // Fetch PC, in-flight count and redirect/drop state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= FETCH_RUN;
      pc_r          <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else begin
      outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(resp_dec_s);
      if (redirect_valid) begin
        pc_r       <= align_pc(redirect_pc);
        drop_cnt_r <= drop_next_s;
        state_r    <= (drop_next_s != '0) ? FETCH_FLUSH : FETCH_RUN;
      end else begin
        if (req_fire_s) begin
          pc_r <= pc_r + 32'd4;
        end
        case (state_r)
          FETCH_RUN: begin
            drop_cnt_r <= '0;
          end
          FETCH_FLUSH: begin
            if (resp_dec_s) begin
              drop_cnt_r <= drop_cnt_r - CW'(1);
              if (drop_cnt_r == CW'(1)) begin
                state_r <= FETCH_RUN;
              end
            end
          end
          default: begin
            state_r    <= FETCH_RUN;
            drop_cnt_r <= '0;
          end
        endcase
      end
    end
  end

`ifdef QU_FETCH_PERF_EN
  // Delivered-instruction and decode-starved cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      perf_fetched <= perf_fetched + 32'(q_pop_s);
      perf_stall   <= perf_stall + 32'(instr_ready && !instr_valid);
    end
  end
`endif

  fetch_checker #(.CW(CW)) u_checker (
    .clk             (clk),
    .rst             (rst),
    .state           (state_r),
    .outstanding     (outstanding_r),
    .imem_resp_valid (imem_resp_valid),
    .q_full          (q_full_s),
    .req_fire        (req_fire_s),
    .resp_push       (resp_push_s),
    .pcq_empty       (pcq_empty_s),
    .pcq_full        (pcq_full_s),
    .pcq_count       (pcq_count_s),
    .pcq_head        (pcq_head_s)
  );

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: a program-order model (epochs, in-flight list, decode queue) predicts every output.
module tb_fetch;
  import qu_common::*;

  localparam int  IQ       = 4;
  localparam pc_t RST_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  pc_t         redirect_pc;
  logic        imem_req_valid;
  pc_t         imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr_out;
  pc_t         pc_out;
  logic        instr_ready;
`ifdef QU_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch #(.INSTR_WIDTH(32), .IQ_DEPTH(IQ), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_ready     (instr_ready)
`ifdef QU_FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    pc_t addr;
    int  epoch;
    int  acc;
  } flight_t;

  flight_t inflight[$];
  pc_t     outq[$];
  int      epoch;
  pc_t     req_pc;
  int      cyc;
  logic    exp_rv;
  logic    pend_redir;
  pc_t     pend_redir_pc;
  int      n_compared;
  int      n_mismatched;

  function automatic logic [31:0] memw(input pc_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_valid"},   32'(imem_req_valid), 32'h0);
    check_val({tag, "_req_addr"},    imem_req_addr, RST_PC);
    check_val({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check_val({tag, "_instr_out"},   instr_out, 32'h0);
    check_val({tag, "_pc_out"},      pc_out, 32'h0);
  endtask

  task automatic model_reset();
    inflight.delete();
    outq.delete();
    epoch++;
    req_pc = RST_PC;
  endtask

  // One clock: drive at negedge, check #1 later, advance the model after the rising edge.
  task automatic step(input int ready_pct, input int resp_pct, input int pop_pct, input int redir_pct);
    logic    flushing;
    logic    fire;
    flight_t f;
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = pc_t'($urandom);
    if (pend_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = pend_redir_pc;
      pend_redir     = 1'b0;
    end else if (int'($urandom_range(99)) < redir_pct) begin
      redirect_valid = 1'b1;
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF5;
    end
    imem_req_ready = int'($urandom_range(99)) < ready_pct;
    if (inflight.size() > 0 && inflight[0].acc < cyc && int'($urandom_range(99)) < resp_pct) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memw(inflight[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    instr_ready = int'($urandom_range(99)) < pop_pct;
    #1;
    flushing = (inflight.size() > 0) && (inflight[0].epoch != epoch);
    exp_rv   = !flushing && ((inflight.size() + outq.size()) < IQ) && !redirect_valid;
    check_val("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check_val("req_addr", imem_req_addr, req_pc);
    check_val("instr_valid", 32'(instr_valid), 32'(outq.size() > 0));
    if (outq.size() > 0) begin
      check_val("pc_out", pc_out, outq[0]);
      check_val("instr_out", instr_out, memw(outq[0]));
    end
    fire = exp_rv && imem_req_ready;
    @(posedge clk);
    if (imem_resp_valid) f = inflight.pop_front();
    if (redirect_valid) begin
      epoch++;
      outq.delete();
      req_pc = redirect_pc & ~32'h3;
    end else begin
      if (outq.size() > 0 && instr_ready) void'(outq.pop_front());
      if (imem_resp_valid && f.epoch == epoch) outq.push_back(f.addr);
      if (fire) begin
        inflight.push_back('{addr: req_pc, epoch: epoch, acc: cyc});
        req_pc = req_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input int ready_pct, input int resp_pct, input int pop_pct, input int redir_pct);
    for (int i = 0; i < n; i++) step(ready_pct, resp_pct, pop_pct, redir_pct);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    instr_ready     = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_compared = 0; n_mismatched = 0; cyc = 1; epoch = 0;
    pend_redir = 1'b0; pend_redir_pc = 32'h0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; instr_ready = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with always-ready memory and decode
    run(20, 100, 100, 100, 0);
    // Decode stalled: credits cap in-flight plus queued at IQ
    run(12, 100, 100, 0, 0);
    run(6, 100, 100, 100, 0);

    // Build up three outstanding requests, then redirect to an unaligned PC
    for (int k = 0; k < 20 && inflight.size() < 3; k++) step(100, 0, 100, 0);
    pend_redir = 1'b1; pend_redir_pc = 32'h0000_0103;
    step(100, 0, 100, 0);
    run(20, 100, 60, 100, 0);

    // PC wrap through 0xFFFFFFFC
    pend_redir = 1'b1; pend_redir_pc = 32'hFFFF_FFF8;
    run(20, 100, 70, 80, 0);

    // Reset in the middle of a flush
    run(3, 100, 0, 100, 0);
    pend_redir = 1'b1; pend_redir_pc = 32'h0000_2000;
    step(100, 0, 100, 0);
    async_reset();
    run(20, 100, 100, 100, 0);

    // Random traffic including redirects that coincide with responses
    for (int c = 0; c < 30; c++) begin
      run(100, int'($urandom_range(20, 100)), int'($urandom_range(10, 100)),
          int'($urandom_range(0, 100)), 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
